// File: rtl/seg7_countdown_ctrl_if.sv
// -----------------------------------------------------------------------------
// seg7_countdown_ctrl_if
// Groups the request inputs and display-control outputs of seg7_countdown_ctrl.
//   master : the side issuing requests (op-select/timer logic, testbench)
//   slave  : the sequencer itself
// Signals:
//   i_start, i_abort, i_ack     request strobes
//   i_op_code[2:0]              op code to latch on accepted start
//   i_load_val[3:0]             countdown start value 0..15
//   o_en, o_disp_mode           display enable / 0 = op symbol, 1 = digit
//   o_op_code[2:0]              latched op code
//   o_digit_val[3:0]            remaining count
//   o_busy, o_done              busy in SHOW_OP/COUNT, done pulse on expiry
// -----------------------------------------------------------------------------
interface seg7_countdown_ctrl_if;
   logic       i_start;
   logic       i_abort;
   logic       i_ack;
   logic [2:0] i_op_code;
   logic [3:0] i_load_val;
   logic       o_en;
   logic       o_disp_mode;
   logic [2:0] o_op_code;
   logic [3:0] o_digit_val;
   logic       o_busy;
   logic       o_done;

   modport master (
      output i_start, i_abort, i_ack, i_op_code, i_load_val,
      input  o_en, o_disp_mode, o_op_code, o_digit_val, o_busy, o_done
   );

   modport slave (
      input  i_start, i_abort, i_ack, i_op_code, i_load_val,
      output o_en, o_disp_mode, o_op_code, o_digit_val, o_busy, o_done
   );
endinterface

// File: rtl/seg7_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// seg7_countdown_ctrl
// Sequencer feeding the display-control inputs of the 7-seg driver. A start
// shows the op symbol for OP_SHOW_TICKS ticks, then counts the loaded value
// down once per tick, pulses o_done at zero and holds "0" until acknowledged.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    seg7_countdown_ctrl_if.slave (requests in, display controls out)
//
// Parameters:
//   TICK_DIV       clk cycles per countdown tick (>= 2)
//   OP_SHOW_TICKS  ticks the op symbol is shown before counting (>= 1)
//   BLINK_DIV      clk cycles per blink half-period (>= 1)
//
// Build option:
//   SEG7_CD_BLINK_EN  when defined, o_en blinks with half-period BLINK_DIV in
//                     EXPIRED; otherwise o_en is a steady 1 there.
// -----------------------------------------------------------------------------
module seg7_countdown_ctrl #(
   parameter int TICK_DIV      = 100_000_000,
   parameter int OP_SHOW_TICKS = 2,
   parameter int BLINK_DIV     = 25_000_000
) (
   input  logic                   clk,
   input  logic                   rst_n,
   seg7_countdown_ctrl_if.slave   bus
);

   localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int TW = $clog2(OP_SHOW_TICKS + 1);
   localparam logic [PW-1:0] PRE_LAST  = PW'(TICK_DIV - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OP_SHOW_TICKS - 1);

   if (TICK_DIV < 2 || OP_SHOW_TICKS < 1 || BLINK_DIV < 1) begin : g_bad_param
      $error("seg7_countdown_ctrl: illegal parameter value");
   end

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHOW_OP,
      S_COUNT,
      S_EXPIRED
   } state_t;

   state_t          state;
   logic [PW-1:0]   pre_cnt;
   logic [TW-1:0]   tick_cnt;
   logic [3:0]      val_lat;

   logic            en_r;
   logic            mode_r;
   logic [2:0]      op_r;
   logic [3:0]      digit_r;
   logic            busy_r;
   logic            done_r;

`ifdef SEG7_CD_BLINK_EN
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
   logic [BW-1:0]   blink_cnt;
`endif

   logic tick;
   assign tick = (pre_cnt == PRE_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pre_cnt  <= '0;
         tick_cnt <= '0;
         val_lat  <= '0;
         en_r     <= 1'b0;
         mode_r   <= 1'b0;
         op_r     <= '0;
         digit_r  <= '0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
`ifdef SEG7_CD_BLINK_EN
         blink_cnt <= '0;
`endif
      end else begin
         // o_done is a single-cycle pulse; only the expiry transition raises it.
         done_r <= 1'b0;

         if (bus.i_abort || (state == S_EXPIRED && bus.i_ack)) begin
            // Abort (any state) or acknowledge: back to IDLE, latches cleared.
            state    <= S_IDLE;
            pre_cnt  <= '0;
            tick_cnt <= '0;
            val_lat  <= '0;
            en_r     <= 1'b0;
            mode_r   <= 1'b0;
            op_r     <= '0;
            digit_r  <= '0;
            busy_r   <= 1'b0;
         end else if ((state == S_IDLE || state == S_EXPIRED) && bus.i_start) begin
            // Accepted start: latch op/value and show the op symbol.
            state    <= S_SHOW_OP;
            pre_cnt  <= '0;
            tick_cnt <= '0;
            val_lat  <= bus.i_load_val;
            en_r     <= 1'b1;
            mode_r   <= 1'b0;
            op_r     <= bus.i_op_code;
            digit_r  <= '0;
            busy_r   <= 1'b1;
         end else begin
            case (state)
               S_SHOW_OP: begin
                  if (!tick) begin
                     pre_cnt <= pre_cnt + 1'b1;
                  end else begin
                     pre_cnt <= '0;
                     if (tick_cnt != TICK_LAST) begin
                        tick_cnt <= tick_cnt + 1'b1;
                     end else if (val_lat == 4'd0) begin
                        // Nothing to count: skip straight to expiry.
                        state   <= S_EXPIRED;
                        en_r    <= 1'b1;
                        mode_r  <= 1'b1;
                        digit_r <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
`ifdef SEG7_CD_BLINK_EN
                        blink_cnt <= '0;
`endif
                     end else begin
                        state   <= S_COUNT;
                        mode_r  <= 1'b1;
                        digit_r <= val_lat;
                     end
                  end
               end

               S_COUNT: begin
                  if (!tick) begin
                     pre_cnt <= pre_cnt + 1'b1;
                  end else begin
                     pre_cnt <= '0;
                     // The tick that would reach 0 is the expiry; <= 1 also
                     // keeps the digit from ever wrapping below zero.
                     if (digit_r <= 4'd1) begin
                        state   <= S_EXPIRED;
                        en_r    <= 1'b1;
                        digit_r <= '0;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
`ifdef SEG7_CD_BLINK_EN
                        blink_cnt <= '0;
`endif
                     end else begin
                        digit_r <= digit_r - 4'd1;
                     end
                  end
               end

               S_EXPIRED: begin
`ifdef SEG7_CD_BLINK_EN
                  if (blink_cnt == BLINK_LAST) begin
                     blink_cnt <= '0;
                     en_r      <= ~en_r;
                  end else begin
                     blink_cnt <= blink_cnt + 1'b1;
                  end
`else
                  en_r <= 1'b1;
`endif
               end

               default: begin
                  // IDLE without an accepted start: hold everything at rest.
                  pre_cnt <= '0;
               end
            endcase
         end
      end
   end

   assign bus.o_en        = en_r;
   assign bus.o_disp_mode = mode_r;
   assign bus.o_op_code   = op_r;
   assign bus.o_digit_val = digit_r;
   assign bus.o_busy      = busy_r;
   assign bus.o_done      = done_r;

endmodule

// File: tb/tb_seg7_countdown_ctrl.sv
// -----------------------------------------------------------------------------
// tb_seg7_countdown_ctrl
// Scoreboard bench for seg7_countdown_ctrl with TICK_DIV=4, OP_SHOW_TICKS=2,
// BLINK_DIV=2. Stimulus pushes hand-computed expected output vectors tagged
// with the clock edge after which they must hold; a monitor on the falling
// edge pops and compares them.
// -----------------------------------------------------------------------------
module tb_seg7_countdown_ctrl;

   logic clk;
   logic rst_n;

   seg7_countdown_ctrl_if bus();

   seg7_countdown_ctrl #(
      .TICK_DIV      (4),
      .OP_SHOW_TICKS (2),
      .BLINK_DIV     (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

`ifdef SEG7_CD_BLINK_EN
   localparam bit BLINK = 1'b1;
`else
   localparam bit BLINK = 1'b0;
`endif

   typedef struct {
      int          cyc;
      logic [10:0] v;
      string       name;
   } exp_t;

   exp_t q[$];
   int   checks   = 0;
   int   failures = 0;
   int   edge_n   = 0;
   int   base     = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) edge_n <= edge_n + 1;

   function automatic logic [10:0] outv();
      return {bus.o_en, bus.o_disp_mode, bus.o_op_code, bus.o_digit_val,
              bus.o_busy, bus.o_done};
   endfunction

   task automatic check(input string nm, input logic [10:0] act, input logic [10:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got en=%b mode=%b op=%0d digit=%0d busy=%b done=%b, want en=%b mode=%b op=%0d digit=%0d busy=%b done=%b",
                  nm, act[10], act[9], act[8:6], act[5:2], act[1], act[0],
                  exp[10], exp[9], exp[8:6], exp[5:2], exp[1], exp[0]);
      end
   endtask

   // Expected outputs after edge base+rel (edge 0 samples the start request).
   function automatic void exp_at(input int rel, input string nm, input logic en,
                                  input logic mode, input logic [2:0] op,
                                  input logic [3:0] dg, input logic busy,
                                  input logic done);
      exp_t e;
      e.cyc  = base + rel;
      e.v    = {en, mode, op, dg, busy, done};
      e.name = nm;
      q.push_back(e);
   endfunction

   // Monitor: compare every expectation due at the edge just passed.
   always @(negedge clk) begin
      while (q.size() > 0 && q[0].cyc <= edge_n) begin
         if (q[0].cyc < edge_n) begin
            checks++;
            failures++;
            $display("FAIL %s: expectation for edge %0d not compared (now %0d)",
                     q[0].name, q[0].cyc, edge_n);
         end else begin
            check(q[0].name, outv(), q[0].v);
         end
         void'(q.pop_front());
      end
   end

   task automatic wait_cycle(input int rel);
      int guard = 0;
      while (edge_n != base + rel - 1) begin
         @(negedge clk);
         guard++;
         if (guard > 2000) begin
            checks++;
            failures++;
            $display("FAIL wait_edge: edge=%0d, required %0d", edge_n, base + rel - 1);
            break;
         end
      end
   endtask

   // Hold the given requests for exactly the edge base+rel.
   task automatic pulse(input int rel, input logic s, input logic a, input logic k,
                        input logic [2:0] op, input logic [3:0] v);
      wait_cycle(rel);
      bus.i_start    = s;
      bus.i_abort    = a;
      bus.i_ack      = k;
      bus.i_op_code  = op;
      bus.i_load_val = v;
      @(negedge clk);
      bus.i_start    = 1'b0;
      bus.i_abort    = 1'b0;
      bus.i_ack      = 1'b0;
      bus.i_op_code  = '0;
      bus.i_load_val = '0;
   endtask

   task automatic new_test();
      @(negedge clk);
      base = edge_n + 1;
   endtask

   initial begin
      int guard;
      rst_n          = 1'b0;
      bus.i_start    = 1'b0;
      bus.i_abort    = 1'b0;
      bus.i_ack      = 1'b0;
      bus.i_op_code  = '0;
      bus.i_load_val = '0;
      #2;
      check("reset_state", outv(), 11'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 1: op=1 val=3 full sequence, then ack.
      new_test();
      exp_at(0,  "t1_show_e0",   1, 0, 1, 0, 1, 0);
      exp_at(7,  "t1_show_e7",   1, 0, 1, 0, 1, 0);
      exp_at(8,  "t1_count3",    1, 1, 1, 3, 1, 0);
      exp_at(11, "t1_hold3",     1, 1, 1, 3, 1, 0);
      exp_at(12, "t1_count2",    1, 1, 1, 2, 1, 0);
      exp_at(16, "t1_count1",    1, 1, 1, 1, 1, 0);
      exp_at(20, "t1_expired",   1, 1, 1, 0, 0, 1);
      exp_at(21, "t1_done_off",  1, 1, 1, 0, 0, 0);
      exp_at(22, "t1_ack_idle",  0, 0, 0, 0, 0, 0);
      pulse(0, 1, 0, 0, 3'd1, 4'd3);
      pulse(22, 0, 0, 1, 3'd0, 4'd0);

      // 2: val=0 skips COUNT; EXPIRED en pattern depends on blink build.
      new_test();
      exp_at(0,  "t2_show",      1, 0, 5, 0, 1, 0);
      exp_at(7,  "t2_show_e7",   1, 0, 5, 0, 1, 0);
      exp_at(8,  "t2_expired",   1, 1, 5, 0, 0, 1);
      exp_at(9,  "t2_en_e9",     1, 1, 5, 0, 0, 0);
      exp_at(10, "t2_en_e10",    BLINK ? 1'b0 : 1'b1, 1, 5, 0, 0, 0);
      exp_at(11, "t2_en_e11",    BLINK ? 1'b0 : 1'b1, 1, 5, 0, 0, 0);
      exp_at(12, "t2_en_e12",    1, 1, 5, 0, 0, 0);
      exp_at(13, "t2_ack_idle",  0, 0, 0, 0, 0, 0);
      pulse(0, 1, 0, 0, 3'd5, 4'd0);
      pulse(13, 0, 0, 1, 3'd0, 4'd0);

      // 3: abort mid-COUNT, then abort+start together in IDLE.
      new_test();
      exp_at(0,  "t3_show",      1, 0, 2, 0, 1, 0);
      exp_at(8,  "t3_count5",    1, 1, 2, 5, 1, 0);
      exp_at(12, "t3_count4",    1, 1, 2, 4, 1, 0);
      exp_at(14, "t3_abort",     0, 0, 0, 0, 0, 0);
      exp_at(24, "t3_idle_e24",  0, 0, 0, 0, 0, 0);
      exp_at(26, "t3_abst_e26",  0, 0, 0, 0, 0, 0);
      exp_at(27, "t3_abst_e27",  0, 0, 0, 0, 0, 0);
      pulse(0, 1, 0, 0, 3'd2, 4'd5);
      pulse(14, 0, 1, 0, 3'd0, 4'd0);
      pulse(26, 1, 1, 0, 3'd6, 4'd7);

      // 4: start ignored in COUNT, restart from EXPIRED, ack beats start.
      new_test();
      exp_at(0,  "t4_show",      1, 0, 3, 0, 1, 0);
      exp_at(8,  "t4_count2",    1, 1, 3, 2, 1, 0);
      exp_at(10, "t4_ign_start", 1, 1, 3, 2, 1, 0);
      exp_at(12, "t4_count1",    1, 1, 3, 1, 1, 0);
      exp_at(16, "t4_expired",   1, 1, 3, 0, 0, 1);
      exp_at(17, "t4_done_off",  1, 1, 3, 0, 0, 0);
      exp_at(18, "t4_restart",   1, 0, 4, 0, 1, 0);
      exp_at(26, "t4_count1b",   1, 1, 4, 1, 1, 0);
      exp_at(30, "t4_expired_b", 1, 1, 4, 0, 0, 1);
      exp_at(31, "t4_ack_wins",  0, 0, 0, 0, 0, 0);
      exp_at(32, "t4_stay_idle", 0, 0, 0, 0, 0, 0);
      pulse(0, 1, 0, 0, 3'd3, 4'd2);
      pulse(10, 1, 0, 0, 3'd6, 4'd9);
      pulse(18, 1, 0, 0, 3'd4, 4'd1);
      pulse(31, 1, 0, 1, 3'd1, 4'd1);

      // 6: asynchronous reset mid-COUNT, then a clean rerun of test 1.
      new_test();
      exp_at(0,  "t6_show",      1, 0, 7, 0, 1, 0);
      exp_at(8,  "t6_count4",    1, 1, 7, 4, 1, 0);
      exp_at(9,  "t6_hold4",     1, 1, 7, 4, 1, 0);
      pulse(0, 1, 0, 0, 3'd7, 4'd4);
      wait_cycle(10);
      #2 rst_n = 1'b0;
      #1 check("t6_async_reset", outv(), 11'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      new_test();
      exp_at(0,  "t6r_show",     1, 0, 1, 0, 1, 0);
      exp_at(8,  "t6r_count3",   1, 1, 1, 3, 1, 0);
      exp_at(12, "t6r_count2",   1, 1, 1, 2, 1, 0);
      exp_at(20, "t6r_expired",  1, 1, 1, 0, 0, 1);
      exp_at(21, "t6r_done_off", 1, 1, 1, 0, 0, 0);
      pulse(0, 1, 0, 0, 3'd1, 4'd3);

      guard = 0;
      while (q.size() > 0 && guard < 2000) begin
         @(negedge clk);
         guard++;
      end
      if (q.size() > 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time %0t exceeded limit", $time);
      $fatal(1, "watchdog");
   end

endmodule
